// File: rtl/frame_sequencer.sv
// frame_sequencer: gates the unpacked pixel stream into the Sobel filters one frame at a time,
// tracks output drain and pulses a clear between frames. Define FRAME_SEQ_WATCHDOG_EN for stall abort.
module frame_sequencer #(
    parameter int width_p     = 320,
    parameter int height_p    = 240,
    parameter int out_beats_p = 76800,
    parameter int timeout_p   = 1048576
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [2:0] button_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       valid_o,
    input  logic       ready_i,
    input  logic       out_valid_i,
    input  logic       out_ready_i,
    output logic [1:0] mode_o,
    output logic       clear_o,
    output logic       frame_active_o,
    output logic [7:0] frame_count_o,
    output logic [7:0] err_count_o
);

    localparam int in_beats_lp  = width_p * height_p;
    localparam int in_cnt_w_lp  = $clog2(in_beats_lp + 1);
    localparam int out_cnt_w_lp = $clog2(out_beats_p + 1);

    localparam logic [in_cnt_w_lp-1:0]  in_last_lp  = in_cnt_w_lp'(in_beats_lp);
    localparam logic [out_cnt_w_lp-1:0] out_last_lp = out_cnt_w_lp'(out_beats_p);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] CLEAR  = 2'd3;

    if (in_beats_lp < 1 || out_beats_p < 1 || timeout_p < 1) begin : g_param_check
        $error("frame_sequencer: frame size, output beats and timeout must be positive");
    end

    function automatic logic [1:0] decode_mode(input logic [2:0] buttons);
        case (buttons)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [1:0]              state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [in_cnt_w_lp-1:0]  in_cnt_q, in_cnt_d;
    logic [out_cnt_w_lp-1:0] out_cnt_q, out_cnt_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;

    logic gate;
    logic in_beat;
    logic out_beat;
    logic frame_active;

    // Handshake gating is purely combinational so the unpacker sees no added latency.
    assign gate         = (state_q == IDLE) || (state_q == STREAM);
    assign ready_o      = ready_i & gate;
    assign valid_o      = valid_i & gate;
    assign in_beat      = valid_i & ready_o;
    assign out_beat     = out_valid_i & out_ready_i;
    assign frame_active = (state_q == STREAM) || (state_q == DRAIN);

`ifdef FRAME_SEQ_WATCHDOG_EN
    localparam int idle_w_lp = $clog2(timeout_p + 1);
    localparam logic [idle_w_lp-1:0] timeout_lp = idle_w_lp'(timeout_p);

    logic [idle_w_lp-1:0] idle_q, idle_d, idle_inc;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 abort_q, abort_d;
    logic                 wd_expire;

    // A beat in the expiry cycle keeps the frame alive.
    always_comb begin
        idle_inc  = idle_q + 1'b1;
        wd_expire = frame_active && !(in_beat || out_beat) && (idle_inc == timeout_lp);
        if (!frame_active || in_beat || out_beat) begin
            idle_d = '0;
        end else begin
            idle_d = idle_inc;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idle_q    <= '0;
            err_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            err_cnt_q <= err_cnt_d;
            abort_q   <= abort_d;
        end
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = '0;
`endif

    // NOTE: every next-state variable takes its current value first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        frame_cnt_d = frame_cnt_q;
`ifdef FRAME_SEQ_WATCHDOG_EN
        err_cnt_d   = err_cnt_q;
        abort_d     = abort_q;
`endif

        // Output beats only count while a frame is in flight, saturating at the frame total.
        if (frame_active && out_beat && (out_cnt_q != out_last_lp)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_beat) begin
                    mode_d    = decode_mode(button_i);
                    in_cnt_d  = in_cnt_w_lp'(1);
                    out_cnt_d = '0;
                    state_d   = (in_beats_lp == 1) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (in_beat) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_d == in_last_lp) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_cnt_d == out_last_lp) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = IDLE;
`ifdef FRAME_SEQ_WATCHDOG_EN
                abort_d   = 1'b0;
                if (abort_q) begin
                    if (err_cnt_q != 8'hff) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
`else
                frame_cnt_d = frame_cnt_q + 8'd1;
`endif
            end
        endcase

`ifdef FRAME_SEQ_WATCHDOG_EN
        // A frame that completes in the same cycle the timer expires is not counted as an abort.
        if (wd_expire && (state_d != CLEAR)) begin
            state_d = CLEAR;
            abort_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign mode_o         = mode_q;
    assign clear_o        = (state_q == CLEAR);
    assign frame_active_o = frame_active;
    assign frame_count_o  = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed frames with a scoreboard of expected per-frame results
// popped whenever the DUT pulses clear_o.
module tb_frame_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [2:0] button_i;
    logic       valid_i, ready_o, valid_o, ready_i;
    logic       out_valid_i, out_ready_i;
    logic [1:0] mode_o;
    logic       clear_o, frame_active_o;
    logic [7:0] frame_count_o, err_count_o;

    frame_sequencer #(
        .width_p    (4),
        .height_p   (2),
        .out_beats_p(8),
        .timeout_p  (16)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .button_i      (button_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .out_valid_i   (out_valid_i),
        .out_ready_i   (out_ready_i),
        .mode_o        (mode_o),
        .clear_o       (clear_o),
        .frame_active_o(frame_active_o),
        .frame_count_o (frame_count_o),
        .err_count_o   (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] frames;
        logic [7:0] errs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   bp_beats;
    logic exp_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // {valid_i, ready_i, out_valid_i, out_ready_i}
    task automatic drive(input logic [3:0] v);
        {valid_i, ready_i, out_valid_i, out_ready_i} = v;
    endtask

    // Scoreboard: each clear_o pulse pops one expected frame result.
    logic       pend = 1'b0;
    logic [7:0] pend_frames = 8'd0;
    logic [7:0] pend_errs = 8'd0;
    always @(negedge clk_i) begin
        if (clear_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_clear", 32'(clear_o), 0);
            end else begin
                check("sb_mode", 32'(mode_o), 32'(exp_q[0].mode));
                pend_frames <= exp_q[0].frames;
                pend_errs   <= exp_q[0].errs;
                pend        <= 1'b1;
                void'(exp_q.pop_front());
            end
        end else if (pend) begin
            check("sb_frame_count", 32'(frame_count_o), 32'(pend_frames));
            check("sb_err_count", 32'(err_count_o), 32'(pend_errs));
            pend <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_ni = 1'b0;
        button_i = 3'b000;
        drive(4'b0000);

        // Reset: gate passes straight through, everything else zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            valid_i = i[0];
            ready_i = i[1];
            #1;
            check("rst_ready_pass", 32'(ready_o), 32'(ready_i));
            check("rst_valid_pass", 32'(valid_o), 32'(valid_i));
        end
        check("rst_mode", 32'(mode_o), 0);
        check("rst_clear", 32'(clear_o), 0);
        check("rst_active", 32'(frame_active_o), 0);
        check("rst_frames", 32'(frame_count_o), 0);
        check("rst_errs", 32'(err_count_o), 0);
        cyc();
        reset_ni = 1'b1;
        drive(4'b0100);
        #1;
        check("post_rst_ready", 32'(ready_o), 1);
        check("post_rst_active", 32'(frame_active_o), 0);

        // Frame 1: button 010, buttons change mid-frame, 8 in beats then 8 out beats.
        exp_q.push_back('{mode: 2'd2, frames: 8'd1, errs: 8'd0});
        cyc();
        button_i = 3'b010;
        drive(4'b1100);
        #1;
        check("f1_mode_before", 32'(mode_o), 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) begin
                check("f1_mode_latched", 32'(mode_o), 2);
                check("f1_active", 32'(frame_active_o), 1);
                button_i = 3'b100;
            end
        end
        #1;
        check("f1_drain_ready", 32'(ready_o), 0);
        check("f1_drain_valid", 32'(valid_o), 0);
        check("f1_drain_active", 32'(frame_active_o), 1);
        drive(4'b0111);
        for (int i = 0; i < 8; i++) begin
            check("f1_no_early_clear", 32'(clear_o), 0);
            cyc();
        end
        drive(4'b0100);
        check("f1_mode_held", 32'(mode_o), 2);
        check("f1_clear_pulse", 32'(clear_o), 1);
        cyc();
        check("f1_clear_one_cycle", 32'(clear_o), 0);
        check("f1_frames", 32'(frame_count_o), 1);
        check("f1_idle_ready", 32'(ready_o), 1);

        // Out beats in IDLE are ignored; frame 2 (button 011) overshoots out beats in STREAM.
        drive(4'b0111);
        repeat (3) cyc();
        check("idle_out_inactive", 32'(frame_active_o), 0);
        exp_q.push_back('{mode: 2'd0, frames: 8'd2, errs: 8'd0});
        button_i = 3'b011;
        drive(4'b1111);
        check("f2_mode_prev", 32'(mode_o), 2);
        cyc();
        check("f2_mode_other", 32'(mode_o), 0);
        repeat (3) cyc();
        drive(4'b0111);
        repeat (3) cyc();
        drive(4'b1111);
        repeat (4) cyc();
        drive(4'b0100);
        check("f2_drain_no_clear", 32'(clear_o), 0);
        check("f2_drain_active", 32'(frame_active_o), 1);
        cyc();
        check("f2_sat_clear", 32'(clear_o), 1);
        cyc();

        // Frame 3: backpressure with ready_i toggling every cycle.
        exp_q.push_back('{mode: 2'd1, frames: 8'd3, errs: 8'd0});
        button_i = 3'b001;
        bp_beats = 0;
        for (int c = 0; c < 20; c++) begin
            drive({1'b1, (c % 2 == 0), 2'b00});
            #1;
            exp_rdy = ready_i && (bp_beats < 8);
            check("bp_ready", 32'(ready_o), 32'(exp_rdy));
            check("bp_valid", 32'(valid_o), 32'(bp_beats < 8));
            if (exp_rdy) bp_beats++;
            cyc();
        end
        check("bp_drain_active", 32'(frame_active_o), 1);
        drive(4'b0111);
        repeat (8) cyc();
        drive(4'b0100);
        check("bp_clear", 32'(clear_o), 1);
        cyc();

        // Frame 4: stall after 3 input beats.
        button_i = 3'b100;
`ifdef FRAME_SEQ_WATCHDOG_EN
        exp_q.push_back('{mode: 2'd3, frames: 8'd3, errs: 8'd1});
        drive(4'b1100);
        repeat (3) cyc();
        drive(4'b0100);
        for (int i = 0; i < 16; i++) begin
            check("wd_no_early_abort", 32'(clear_o), 0);
            cyc();
        end
        check("wd_abort_clear", 32'(clear_o), 1);
        cyc();
        check("wd_back_idle", 32'(frame_active_o), 0);
        check("wd_errs", 32'(err_count_o), 1);
        check("wd_frames_kept", 32'(frame_count_o), 3);

        // A beat on the expiry cycle keeps the frame alive.
        exp_q.push_back('{mode: 2'd3, frames: 8'd4, errs: 8'd1});
        drive(4'b1100);
        repeat (3) cyc();
        drive(4'b0100);
        repeat (15) cyc();
        drive(4'b1100);
        cyc();
        check("wd_beat_wins_clear", 32'(clear_o), 0);
        check("wd_beat_wins_active", 32'(frame_active_o), 1);
        repeat (4) cyc();
        drive(4'b0111);
        repeat (8) cyc();
        drive(4'b0100);
        check("wd_resumed_clear", 32'(clear_o), 1);
        cyc();
`else
        exp_q.push_back('{mode: 2'd3, frames: 8'd4, errs: 8'd0});
        drive(4'b1100);
        repeat (3) cyc();
        drive(4'b0100);
        repeat (40) cyc();
        check("stall_still_active", 32'(frame_active_o), 1);
        check("stall_no_clear", 32'(clear_o), 0);
        check("stall_errs", 32'(err_count_o), 0);
        drive(4'b1100);
        repeat (5) cyc();
        drive(4'b0111);
        repeat (8) cyc();
        drive(4'b0100);
        check("stall_resumed_clear", 32'(clear_o), 1);
        cyc();
`endif

        // Frame 5: asynchronous reset in DRAIN after 5 output beats.
        button_i = 3'b010;
        drive(4'b1100);
        repeat (8) cyc();
        drive(4'b0111);
        repeat (5) cyc();
        drive(4'b0100);
        #2;
        reset_ni = 1'b0;
        #1;
        check("arst_active", 32'(frame_active_o), 0);
        check("arst_ready", 32'(ready_o), 1);
        check("arst_frames", 32'(frame_count_o), 0);
        check("arst_mode", 32'(mode_o), 0);
        check("arst_clear", 32'(clear_o), 0);
        cyc();
        reset_ni = 1'b1;
        repeat (10) cyc();
        check("arst_no_clear", 32'(clear_o), 0);

        // Frame 6: clean frame after the reset starts counting from zero.
        exp_q.push_back('{mode: 2'd1, frames: 8'd1, errs: 8'd0});
        button_i = 3'b001;
        drive(4'b1100);
        repeat (8) cyc();
        drive(4'b0111);
        repeat (8) cyc();
        drive(4'b0100);
        check("f6_clear", 32'(clear_o), 1);
        cyc();
        check("f6_frames", 32'(frame_count_o), 1);
        repeat (2) cyc();

        check("sb_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the pixel pipeline between the unpacker and the Sobel/magnitude/packer chain. It gates the unpacked pixel stream into the gradient filters one frame at a time, latches the output-mode selection from the buttons at frame start, and tracks output beats to know when a frame has fully drained. After each frame it pulses a clear to the filters' line buffers and the packer. A watchdog aborts and resynchronises a stalled frame.

## Interface
Parameters:
- width_p, 320, pixels per line
- height_p, 240, lines per frame; input beats per frame = width_p*height_p
- out_beats_p, 76800, output beats expected per frame at the packer input
- timeout_p, 1048576, idle cycles mid-frame before abort (watchdog builds only)

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- reset_ni  in  1  asynchronous, active-low reset
- button_i  in  3  raw mode buttons [3:1]
- valid_i  in  1  pixel valid from unpacker
- ready_o  out  1  ready to unpacker
- valid_o  out  1  pixel valid to both Sobel filters
- ready_i  in  1  AND of both Sobel ready outputs
- out_valid_i  in  1  packer-input valid (monitor only)
- out_ready_i  in  1  packer ready (monitor only)
- mode_o  out  2  latched mode: 0 magnitude, 1 raw, 2 gx, 3 gy
- clear_o  out  1  one-cycle synchronous clear to filters and packer
- frame_active_o  out  1  high in STREAM and DRAIN
- frame_count_o  out  8  completed frames, wraps 255->0
- err_count_o  out  8  watchdog aborts, saturates at 255

## Operation
- Gate g = (state==IDLE || state==STREAM). valid_o = valid_i & g; ready_o = ready_i & g (combinational, no added latency). Pixel data bypasses this block.
- Input beat: valid_i & ready_o. Output beat: out_valid_i & out_ready_i.
- IDLE: on the first input beat, latch mode from button_i (001->1, 010->2, 100->3, any other->0), set in_cnt=1, clear out_cnt, go STREAM. Buttons are ignored outside this cycle.
- STREAM: in_cnt increments per input beat. The beat bringing in_cnt to width_p*height_p moves to DRAIN.
- DRAIN: the gate is closed. Wait until out_cnt == out_beats_p, then go CLEAR.
- CLEAR: clear_o=1 for exactly one cycle. frame_count_o increments. Zero in_cnt and out_cnt. Go IDLE.
- out_cnt increments on output beats in STREAM and DRAIN, saturating at out_beats_p. Output beats in IDLE or CLEAR are ignored.
- Counter widths: $clog2(width_p*height_p+1) and $clog2(out_beats_p+1).

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; mode_o=0; clear_o=0; frame_active_o=0; frame_count_o=0; err_count_o=0; all counters=0.
  - ready_o and valid_o follow the gate, so they are live immediately after reset.
- Reset mid-frame discards the frame. No clear_o pulse is issued and the counters are not retained.
- mode_o changes on the clock edge that ends the IDLE handshake cycle. It is stable for the whole frame.
- Last input beat to first DRAIN cycle: 1 clock. Last output beat to clear_o high: 1 clock (DRAIN to CLEAR). clear_o high to IDLE: 1 clock.
- Minimum gap between frames: the DRAIN duration plus 1 CLEAR cycle.
- frame_count_o updates on the edge leaving CLEAR.

## Configuration
- FRAME_SEQ_WATCHDOG_EN defined:
  - An idle counter runs in STREAM and DRAIN. It resets on any input or output beat.
  - When the counter reaches timeout_p, the block goes to CLEAR and increments err_count_o, not frame_count_o.
  - If a beat and expiry occur in the same cycle, the beat wins.
- Undefined: no watchdog logic. err_count_o is tied to 0 and a stalled frame waits indefinitely.

## Test plan
Parameters for all scenarios: width_p=4, height_p=2, out_beats_p=8, timeout_p=16.
- Reset: hold reset_ni=0 while toggling valid_i and ready_i -> all outputs 0 except the gate passthrough. Release -> IDLE with ready_o==ready_i.
- Clean frame, button_i=010: send 8 input beats, then 8 output beats -> mode_o=2 from the cycle after the first beat; ready_o=0 in DRAIN; clear_o high exactly 1 cycle, 1 clock after the 8th output beat; frame_count_o=1.
- Mode latch: change button_i to 100 mid-frame -> mode_o remains 2. Next frame with button_i=011 -> mode_o=0.
- Backpressure: ready_i toggles every cycle while valid_i=1 -> exactly 8 beats counted and the gate closes on the 8th.
- Watchdog (macro defined): 3 input beats, then silence for 16 cycles -> clear_o pulse, err_count_o=1, frame_count_o unchanged, back in IDLE. A beat arriving on the expiry cycle prevents the abort.
- Async reset in DRAIN after 5 output beats -> immediate IDLE, no clear_o pulse, frame_count_o=0.
